// File: rtl/k2red_pkg.sv
// Shared widths, mode encoding and stage payload for the K-RED/K2-RED reducer.
package k2red_pkg;

  localparam int unsigned QW = 64;                // modulus / result width
  localparam int unsigned KW = 33;                // width of k
  localparam int unsigned MW = $clog2(2 * QW);    // width of split position m
  localparam int unsigned CW = 2 * QW + KW + 1;   // signed intermediate width, no truncation

  localparam logic MODE_KRED  = 1'b0;
  localparam logic MODE_K2RED = 1'b1;

  // Payload carried by a pipeline stage together with its own reduction parameters
  typedef struct packed {
    logic signed [CW-1:0] data;
    logic [QW-1:0]        q;
    logic [KW-1:0]        k;
    logic [MW-1:0]        m;
    logic                 mode;
  } stage_t;

endpackage

// File: rtl/k2red_split.sv
// Combinational split S(X, m): xl = X & (2^m - 1), xh = X >>> m (arithmetic).
// Ports:
//   x  - signed operand
//   m  - split position
//   xh - arithmetic high part (signed)
//   xl - low m bits, zero-extended
module k2red_split #(
  parameter int unsigned W  = 162,
  parameter int unsigned SW = 7
) (
  input  logic signed [W-1:0]  x,
  input  logic        [SW-1:0] m,
  output logic signed [W-1:0]  xh,
  output logic        [W-1:0]  xl
);

  logic [W-1:0] mask;

  assign mask = (W'(1) << m) - W'(1);
  assign xl   = x & mask;
  assign xh   = x >>> m;

endmodule

// File: rtl/k2red_pipe.sv
// Three-stage pipelined K-RED / K2-RED reducer for Q = k*2^m + 1.
// Returns k*A mod Q (mode 0) or k^2*A mod Q (mode 1), fully reduced into [0, Q).
// Widths come from k2red_pkg (QW, KW, MW, CW).
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - input handshake; in_ready = !out_valid || out_ready
//   in_mode, A, Q, k, m - per-transaction operand and reduction parameters
//   out_valid/out_ready - output handshake
//   C                   - reduced result, updated only when a new result lands
//   busy                - any stage holds a valid transaction
module k2red_pipe
  import k2red_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mode,
  input  logic [2*QW-1:0] A,
  input  logic [QW-1:0]   Q,
  input  logic [KW-1:0]   k,
  input  logic [MW-1:0]   m,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [QW-1:0]   C,
  output logic            busy
);

  logic en_c;

  // stage 1 register: C1 plus parameters
  stage_t s1_d, s1_q;
  logic   v1_q;

  // stage 2 register: C2 and the modulus needed for correction
  logic signed [CW-1:0] c2_d, c2_q;
  logic [QW-1:0]        q2_q;
  logic                 v2_q;

  logic signed [CW-1:0] a_hi, c1_hi;
  logic [CW-1:0]        a_lo, c1_lo;
  logic signed [CW-1:0] q_ext;
  logic [QW-1:0]        c3_c;

  // Whole pipeline moves together; a held output freezes everything
  assign en_c     = !out_valid || out_ready;
  assign in_ready = en_c;
  assign busy     = v1_q | v2_q | out_valid;

  // S1: C1 = k*AL - AH on the zero-extended product
  k2red_split #(.W(CW), .SW(MW)) u_split_a (
    .x  ($signed(CW'(A))),
    .m  (m),
    .xh (a_hi),
    .xl (a_lo)
  );

  always_comb begin
    s1_d      = '0;
    s1_d.data = $signed(CW'(k)) * $signed(a_lo) - a_hi;
    s1_d.q    = Q;
    s1_d.k    = k;
    s1_d.m    = m;
    s1_d.mode = in_mode;
  end

  // S2: second K-RED step in K2-RED mode, otherwise pass C1 through
  k2red_split #(.W(CW), .SW(MW)) u_split_c1 (
    .x  (s1_q.data),
    .m  (s1_q.m),
    .xh (c1_hi),
    .xl (c1_lo)
  );

  always_comb begin
    c2_d = s1_q.data;
    if (s1_q.mode == MODE_K2RED) begin
      c2_d = $signed(CW'(s1_q.k)) * $signed(c1_lo) - c1_hi;
    end
  end

  // S3: single conditional add/subtract of Q brings C2 into [0, Q)
  assign q_ext = $signed(CW'(q2_q));

  always_comb begin
    c3_c = QW'(c2_q);
    if (c2_q[CW-1]) begin
      c3_c = QW'(c2_q + q_ext);
    end else if (c2_q >= q_ext) begin
      c3_c = QW'(c2_q - q_ext);
    end
  end

  // Stage registers and valid chain; bubbles advance like data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      s1_q      <= '0;
      v2_q      <= 1'b0;
      c2_q      <= '0;
      q2_q      <= '0;
      out_valid <= 1'b0;
      C         <= '0;
    end else if (en_c) begin
      v1_q      <= in_valid;
      s1_q      <= s1_d;
      v2_q      <= v1_q;
      c2_q      <= c2_d;
      q2_q      <= s1_q.q;
      out_valid <= v2_q;
      if (v2_q) begin
        C <= c3_c;
      end
    end
  end

endmodule

// File: tb/tb_k2red_pipe.sv
// Directed and randomised bench for k2red_pipe with an in-order result scoreboard.
module tb_k2red_pipe;
  import k2red_pkg::*;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic            in_mode;
  logic [2*QW-1:0] A;
  logic [QW-1:0]   Q;
  logic [KW-1:0]   k;
  logic [MW-1:0]   m;
  logic            out_valid;
  logic            out_ready;
  logic [QW-1:0]   C;
  logic            busy;

  int vecs;
  int errs;
  int cyc;
  int ordy_mode;
  logic rnd_bit;
  logic [QW-1:0] sbq[$];

  k2red_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .A         (A),
    .Q         (Q),
    .k         (k),
    .m         (m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  assign out_ready = (ordy_mode == 1) || ((ordy_mode == 2) && rnd_bit);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor: every accepted result must match the oldest pending expectation
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
    end else if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check("spurious_out", 128'(sbq.size()), 128'(1));
      end else begin
        check("result", 128'(C), 128'(sbq.pop_front()));
      end
    end
  end

  // Present one transaction and wait (bounded) until it is accepted
  task automatic drive(input logic md, input logic [2*QW-1:0] a, input logic [QW-1:0] q,
                       input logic [KW-1:0] kk, input logic [MW-1:0] mm, input logic [QW-1:0] exp);
    in_mode  = md;
    A        = a;
    Q        = q;
    k        = kk;
    m        = mm;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back(exp);
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("accept_timeout", 128'(in_ready), 128'(1));
    in_valid = 1'b0;
  endtask

  // Single transaction into an empty pipe: check latency and value
  task automatic send_lat(input string tag, input logic md, input logic [2*QW-1:0] a,
                          input logic [QW-1:0] q, input logic [KW-1:0] kk,
                          input logic [MW-1:0] mm, input logic [QW-1:0] exp);
    int lat;
    drive(md, a, q, kk, mm, exp);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 128'(lat), 128'(3));
    check({tag, "_C"}, 128'(C), 128'(exp));
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    ordy_mode = 1;
    n = 0;
    while ((sbq.size() != 0 || busy) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_pending", 128'(sbq.size()), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  logic [KW-1:0]   kt [6];
  int              mt [6];
  logic [127:0]    r, av;
  logic [QW-1:0]   qv, ev;
  logic [255:0]    t;
  int              sel;
  logic            md;
  int              c0;
  logic            stayed_idle;

  initial begin
    vecs = 0;
    errs = 0;
    ordy_mode = 1;
    rst = 1'b1;
    in_valid = 1'b0;
    in_mode = 1'b0;
    A = '0;
    Q = '0;
    k = '0;
    m = '0;

    kt[0] = 33'd3;       mt[0] = 4;
    kt[1] = 33'd15;      mt[1] = 9;
    kt[2] = 33'd5;       mt[2] = 10;
    kt[3] = 33'd255;     mt[3] = 50;
    kt[4] = 33'd1048575; mt[4] = 40;
    kt[5] = 33'd1;       mt[5] = 63;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_C", 128'(C), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: K2-RED, no correction; 2: K-RED, negative correction
    send_lat("t1", 1'b1, 128'd1000, 64'd49, 33'd3, 7'd4, 64'd33);
    drain();
    send_lat("t2", 1'b0, 128'd1000, 64'd49, 33'd3, 7'd4, 64'd11);
    drain();

    // 3: back-to-back with parameters changing every cycle
    c0 = cyc;
    drive(1'b1, 128'd7680, 64'd7681, 33'd15, 7'd9, 64'd7456);
    drive(1'b1, 128'd0,    64'd7681, 33'd15, 7'd9, 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 128'd1000, 64'd49,   33'd3,  7'd4, 64'd33);
      drive(1'b1, 128'd7680, 64'd7681, 33'd15, 7'd9, 64'd7456);
    end
    check("t3_throughput", 128'(cyc - c0), 128'(8));
    drain();

    // 4: backpressure with 4 operands
    ordy_mode = 0;
    drive(1'b1, 128'd1000, 64'd49,   33'd3,  7'd4, 64'd33);
    drive(1'b1, 128'd7680, 64'd7681, 33'd15, 7'd9, 64'd7456);
    drive(1'b1, 128'd0,    64'd7681, 33'd15, 7'd9, 64'd0);
    in_mode  = 1'b0;
    A        = 128'd1000;
    Q        = 64'd49;
    k        = 33'd3;
    m        = 7'd4;
    in_valid = 1'b1;
    check("t4_in_ready_stall", 128'(in_ready), 128'(0));
    check("t4_out_valid", 128'(out_valid), 128'(1));
    check("t4_C_first", 128'(C), 128'(33));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("t4_in_ready_hold", 128'(in_ready), 128'(0));
      check("t4_C_hold", 128'(C), 128'(33));
    end
    ordy_mode = 1;
    drive(1'b0, 128'd1000, 64'd49, 33'd3, 7'd4, 64'd11);
    drain();

    // 5: reset with transactions in flight
    drive(1'b1, 128'd1000, 64'd49,   33'd3,  7'd4, 64'd33);
    drive(1'b1, 128'd7680, 64'd7681, 33'd15, 7'd9, 64'd7456);
    drive(1'b0, 128'd1000, 64'd49,   33'd3,  7'd4, 64'd11);
    in_valid = 1'b0;
    check("t5_busy_before", 128'(busy), 128'(1));
    #2;
    rst = 1'b1;
    #1;
    check("t5_out_valid", 128'(out_valid), 128'(0));
    check("t5_busy", 128'(busy), 128'(0));
    check("t5_C", 128'(C), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    stayed_idle = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) stayed_idle = 1'b0;
    end
    check("t5_no_ghost_out", 128'(stayed_idle), 128'(1));
    send_lat("t5_after", 1'b1, 128'd7680, 64'd7681, 33'd15, 7'd9, 64'd7456);
    drain();

    // 6: random operands, parameters, gaps and stalls against k^e*A mod Q
    ordy_mode = 2;
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 5);
      md  = 1'($urandom_range(0, 1));
      qv  = (64'(kt[sel]) << mt[sel]) + 64'd1;
      r   = {$urandom, $urandom, $urandom, $urandom};
      if (md) av = r % (128'(qv) * 128'(qv));
      else    av = r % 128'(qv);
      t = 256'(kt[sel]) * 256'(av);
      if (md) t = t * 256'(kt[sel]);
      ev = 64'(t % 256'(qv));
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      drive(md, av, qv, kt[sel], 7'(mt[sel]), ev);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
